button_conditioner: RTL and testbench

Parametrised multi-channel input conditioner for the alarm clock's asynchronous push-buttons and switches (set, hour, minute, alarm-enable, snooze). Each channel runs through a configurable-depth flip-flop synchroniser, then a stability-count debouncer, then an edge detector. The block outputs a clean level plus single-cycle rise and fall pulses to the control FSMs. It is the generalised successor to the fixed two-stage, single-bit synchroniser: configurable depth and channel count, with debounce and edge detection added.

---
 rtl/button_conditioner.sv | 73 +++++++
 tb/tb_button_conditioner.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Multi-channel input conditioner: N-stage synchroniser, stability-count debouncer and
// registered rise/fall pulse generation for asynchronous buttons and switches.
module button_conditioner #(
   parameter int unsigned CHANNELS       = 4,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned DEBOUNCE_COUNT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] sig_in,
   output logic [CHANNELS-1:0] sig_sync,
   output logic [CHANNELS-1:0] sig_db,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_COUNT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_COUNT - 1);

   // Stage 0 is the only flop that samples sig_in asynchronously; keep the chain adjacent.
   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      end
   end

   assign sig_sync = sync_q[SYNC_STAGES-1];

   logic [CHANNELS-1:0] mismatch;
   logic [CHANNELS-1:0] accept;

   assign mismatch = sig_sync ^ sig_db;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      assign accept[c] = mismatch[c] && (cnt_q == CNT_LAST);

      // Any cycle of agreement, or an accept, restarts the stability count.
      always_comb begin
         cnt_d = '0;
         if (mismatch[c] && !accept[c]) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_db <= '0;
         rise   <= '0;
         fall   <= '0;
      end else begin
         sig_db <= (sig_db & ~accept) | (sig_sync & accept);
         rise   <= accept & sig_sync;
         fall   <= accept & ~sig_sync;
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: default instance checked every cycle against a queue-based
// model plus directed timing sequences; a DEBOUNCE_COUNT=1/SYNC_STAGES=3 instance is table-driven.
module tb_button_conditioner;

   localparam int S = 2;
   localparam int D = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sig_in, sig_sync, sig_db, rise, fall;
   logic [3:0] sig_in2, sig_sync2, sig_db2, rise2, fall2;

   always #5 clk = ~clk;

   button_conditioner #(.CHANNELS(4), .SYNC_STAGES(S), .DEBOUNCE_COUNT(D)) dut (
      .clk(clk), .rst(rst), .sig_in(sig_in), .sig_sync(sig_sync), .sig_db(sig_db),
      .rise(rise), .fall(fall)
   );

   button_conditioner #(.CHANNELS(4), .SYNC_STAGES(3), .DEBOUNCE_COUNT(1)) dut2 (
      .clk(clk), .rst(rst), .sig_in(sig_in2), .sig_sync(sig_sync2), .sig_db(sig_db2),
      .rise(rise2), .fall(fall2)
   );

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference model: sig_sync is sig_in delayed S-1 edges; a channel accepts when the last D
   // pre-edge sig_sync samples all disagree with its debounced level.
   logic [3:0] m_in_q[$];
   logic [3:0] m_sh[$];
   logic [3:0] m_sync, m_db, m_rise, m_fall;

   task automatic model_reset();
      m_in_q = {};
      for (int i = 0; i < S; i++) m_in_q.push_front(4'h0);
      m_sh = {};
      m_sync = '0; m_db = '0; m_rise = '0; m_fall = '0;
   endtask

   task automatic model_step();
      logic [3:0] old;
      logic [3:0] acc;
      old = m_sync;
      m_sh.push_back(old);
      if (m_sh.size() > D) void'(m_sh.pop_front());
      acc = '0;
      for (int c = 0; c < 4; c++) begin
         if (m_sh.size() == D) begin
            acc[c] = 1'b1;
            foreach (m_sh[j]) if (m_sh[j][c] == m_db[c]) acc[c] = 1'b0;
         end
      end
      m_rise = acc & old;
      m_fall = acc & ~old;
      m_db   = (m_db & ~acc) | (old & acc);
      m_in_q.push_front(sig_in);
      m_sync = m_in_q[S-1];
      void'(m_in_q.pop_back());
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      cyc++;
      #1;
      check("model", {48'h0, sig_sync, sig_db, rise, fall}, {48'h0, m_sync, m_db, m_rise, m_fall});
   endtask

   typedef struct packed {
      logic [3:0] in;
      logic [3:0] sync;
      logic [3:0] db;
      logic [3:0] rise;
      logic [3:0] fall;
   } vec_t;

   vec_t tbl [14];

   int t0, fs, fd, nr, nf, nx, f1, r3;

   initial begin
      tbl[0]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[1]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[2]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[3]  = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
      tbl[4]  = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
      tbl[5]  = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0};
      tbl[6]  = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0};
      tbl[7]  = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
      tbl[8]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h1};
      tbl[9]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[10] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
      tbl[11] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h0};
      tbl[12] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
      tbl[13] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

      rst = 1'b1; sig_in = '0; sig_in2 = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", {32'h0, sig_sync, sig_db, rise, fall, sig_sync2, sig_db2, rise2, fall2},
            64'h0);
      @(negedge clk) rst = 1'b0;

      // Degenerate instance: step, 1-cycle pulse, consecutive rise/fall.
      for (int i = 0; i < 14; i++) begin
         sig_in2 = tbl[i].in;
         tick();
         check($sformatf("degen_k%0d", i + 1), {44'h0, sig_sync2, sig_db2, rise2, fall2},
               {44'h0, tbl[i].sync, tbl[i].db, tbl[i].rise, tbl[i].fall});
      end
      sig_in2 = '0;

      // Clean press on channel 0.
      t0 = cyc; sig_in[0] = 1'b1; fs = -1; fd = -1; nr = 0; nx = 0;
      repeat (40) begin
         tick();
         if (sig_sync[0] && fs < 0) fs = cyc - t0;
         if (sig_db[0] && fd < 0) fd = cyc - t0;
         nr += int'(rise[0]);
         if ({rise[3:1], fall, sig_db[3:1], sig_sync[3:1]} != '0) nx++;
      end
      check("press_sync_edge", 64'(fs), 64'd2);
      check("press_db_edge", 64'(fd), 64'd18);
      check("press_rise_count", 64'(nr), 64'd1);
      check("press_others_quiet", 64'(nx), 64'd0);

      // Bounce on channel 2: 5 high / 3 low for 60 cycles, then held high.
      nx = 0;
      for (int i = 0; i < 60; i++) begin
         if (i == 56) t0 = cyc;
         sig_in[2] = ((i % 8) < 5);
         tick();
         if (sig_db[2] | rise[2] | fall[2]) nx++;
      end
      check("bounce_quiet", 64'(nx), 64'd0);
      fd = -1; nr = 0;
      repeat (30) begin
         tick();
         if (sig_db[2] && fd < 0) fd = cyc - t0;
         nr += int'(rise[2]);
      end
      check("bounce_db_edge", 64'(fd), 64'd18);
      check("bounce_rise_count", 64'(nr), 64'd1);

      // Release channel 1 on the same cycle channel 3 is pressed.
      sig_in[1] = 1'b1;
      repeat (25) tick();
      t0 = cyc; sig_in[1] = 1'b0; sig_in[3] = 1'b1; f1 = -1; r3 = -1; nx = 0;
      repeat (25) begin
         tick();
         if (fall[1] && f1 < 0) f1 = cyc - t0;
         if (rise[3] && r3 < 0) r3 = cyc - t0;
         if ({rise[2], rise[0], fall[2], fall[0]} != '0 || !sig_db[0] || !sig_db[2]) nx++;
      end
      check("release_fall1_edge", 64'(f1), 64'd18);
      check("simul_rise3_edge", 64'(r3), 64'd18);
      check("simul_ch02_quiet", 64'(nx), 64'd0);

      // Near-threshold: 15-cycle mismatch is rejected, 16-cycle mismatch is accepted.
      nf = 0; nx = 0;
      sig_in[0] = 1'b0;
      repeat (15) begin tick(); nf += int'(fall[0]); if (!sig_db[0]) nx++; end
      sig_in[0] = 1'b1;
      repeat (25) begin tick(); nf += int'(fall[0]); if (!sig_db[0]) nx++; end
      check("glitch15_no_fall", 64'(nf), 64'd0);
      check("glitch15_db_held", 64'(nx), 64'd0);
      t0 = cyc; sig_in[0] = 1'b0; fd = -1; nf = 0; nr = 0;
      repeat (16) begin tick(); nf += int'(fall[0]); if (fall[0] && fd < 0) fd = cyc - t0; end
      sig_in[0] = 1'b1;
      repeat (40) begin
         tick();
         nf += int'(fall[0]); nr += int'(rise[0]);
         if (fall[0] && fd < 0) fd = cyc - t0;
      end
      check("glitch16_fall_edge", 64'(fd), 64'd18);
      check("glitch16_fall_count", 64'(nf), 64'd1);
      check("glitch16_rise_count", 64'(nr), 64'd1);

      // Randomised toggling with mixed run lengths, checked against the model each cycle.
      repeat (3000) begin
         for (int c = 0; c < 4; c++) if ($urandom_range(0, 11) == 0) sig_in[c] = ~sig_in[c];
         tick();
      end

      // Asynchronous reset mid-cycle while rise pulses are high, then full latency again.
      sig_in = '0;
      repeat (40) tick();
      sig_in = 4'hF;
      repeat (18) tick();
      check("rst_pre_rise", {60'h0, rise}, 64'hF);
      #2 rst = 1'b1;
      model_reset();
      #1;
      check("rst_async_clear", {48'h0, sig_sync, sig_db, rise, fall}, 64'h0);
      repeat (2) tick();
      check("rst_held", {48'h0, sig_sync, sig_db, rise, fall}, 64'h0);
      @(negedge clk) rst = 1'b0;
      t0 = cyc; fd = -1; nr = 0;
      repeat (25) begin
         tick();
         if (sig_db == 4'hF && fd < 0) fd = cyc - t0;
         if (rise == 4'hF) nr++;
      end
      check("rst_relatency", 64'(fd), 64'd18);
      check("rst_rise_once", 64'(nr), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
